// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions: stall cause encodings, the hard-wired zero
// register and the source/destination match helper used by ID hazard logic.
package hazard_detection_unit_pkg;

  localparam int REG_W = 5;

  // Register 0 always reads as zero, so it can never carry a dependency.
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_LOAD   = 2'b01,
    CAUSE_BRANCH = 2'b10,
    CAUSE_MDU    = 2'b11
  } stall_cause_e;

  // True when a producer destination feeds a source the consumer really reads.
  function automatic logic src_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic             use_src);
    return (rd != REG_ZERO) && (rd == rs) && use_src;
  endfunction

endpackage

// File: rtl/hazard_detection_unit_mdu_scoreboard.sv
// Tracks the single in-flight multiply/divide: a countdown of cycles until its
// result is readable from the register file, and the register it will write.
module hazard_detection_unit_mdu_scoreboard
  import hazard_detection_unit_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdu_issue,
  input  logic [REG_W-1:0] issue_rd,
  output logic             mdu_busy,
  output logic [REG_W-1:0] mdu_rd
);

  // The issue edge itself is the first latency cycle, so load one less.
  localparam logic [3:0] CNT_RELOAD = 4'(MDU_LAT - 1);

  logic [3:0] cnt;

  // Reload on issue (wins over the decrement), otherwise count down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= 4'd0;
      mdu_rd <= REG_ZERO;
    end else if (mdu_issue) begin
      cnt    <= CNT_RELOAD;
      mdu_rd <= issue_rd;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign mdu_busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard detector: freezes PC and IF/ID and bubbles ID/EX for
// hazards forwarding cannot cover (load-use, ID branch operands, pending MDU
// results), squashes IF/ID on taken branches, and counts stalled cycles.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RS1_IFID,
  input  logic [REG_W-1:0] RS2_IFID,
  input  logic             useRS1_ID,
  input  logic             useRS2_ID,
  input  logic             branch_ID,
  input  logic             branchTaken_ID,
  input  logic             mdu_ID,
  input  logic [REG_W-1:0] RD_IDEX,
  input  logic             writeBack_IDEX,
  input  logic             memRead_IDEX,
  input  logic             mdu_IDEX,
  input  logic [REG_W-1:0] RD_EXMEM,
  input  logic             memRead_EXMEM,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             mdu_busy,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [REG_W-1:0] mdu_rd;
  logic             ex_dep;
  logic             mem_dep;
  logic             mdu_dep;
  logic             load_use_haz;
  logic             branch_haz;
  logic             mdu_haz;
  logic             stall;
  stall_cause_e     cause;

  hazard_detection_unit_mdu_scoreboard #(
    .MDU_LAT (MDU_LAT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .mdu_issue (mdu_IDEX),
    .issue_rd  (RD_IDEX),
    .mdu_busy  (mdu_busy),
    .mdu_rd    (mdu_rd)
  );

  // Does the ID instruction read what EX, MEM or the pending MDU op will write.
  assign ex_dep  = src_match(RD_IDEX,  RS1_IFID, useRS1_ID) || src_match(RD_IDEX,  RS2_IFID, useRS2_ID);
  assign mem_dep = src_match(RD_EXMEM, RS1_IFID, useRS1_ID) || src_match(RD_EXMEM, RS2_IFID, useRS2_ID);
  assign mdu_dep = src_match(mdu_rd,   RS1_IFID, useRS1_ID) || src_match(mdu_rd,   RS2_IFID, useRS2_ID);

  // A load in EX delays its data past EX forwarding; an ID branch needs its
  // operands in ID, so any EX writer or a MEM load is too late for it.
  assign load_use_haz = memRead_IDEX && ex_dep;
  assign branch_haz   = branch_ID && ((writeBack_IDEX && ex_dep) || (memRead_EXMEM && mem_dep));
  assign mdu_haz      = mdu_busy && (mdu_dep || mdu_ID);
  assign stall        = load_use_haz || branch_haz || mdu_haz;

  // Cause priority and pipeline controls; a stalled branch is not yet resolved
  // so its flush is held back until it actually leaves ID.
  always_comb begin
    cause       = CAUSE_NONE;
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEX_bubble = 1'b0;
    IFID_flush  = branchTaken_ID;
    if (load_use_haz) begin
      cause = CAUSE_LOAD;
    end else if (branch_haz) begin
      cause = CAUSE_BRANCH;
    end else if (mdu_haz) begin
      cause = CAUSE_MDU;
    end
    if (stall) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEX_bubble = 1'b1;
      IFID_flush  = 1'b0;
    end
  end

  assign stall_cause = cause;

  // Saturating count of stalled cycles for performance readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit (MDU_LAT=4, CNT_W=4).
module tb_hazard_detection_unit;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;

  // Control bundle {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush}.
  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_FLUSH = 4'b1101;
  localparam logic [3:0] CTL_STALL = 4'b0010;

  logic             clk;
  logic             rst;
  logic [4:0]       RS1_IFID, RS2_IFID, RD_IDEX, RD_EXMEM;
  logic             useRS1_ID, useRS2_ID, branch_ID, branchTaken_ID, mdu_ID;
  logic             writeBack_IDEX, memRead_IDEX, mdu_IDEX, memRead_EXMEM;
  logic             PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, mdu_busy;
  logic [1:0]       stall_cause;
  logic [CNT_W-1:0] stall_cycles;
  logic [3:0]       ctl;

  int n_checks;
  int n_errors;

  assign ctl = {PCWrite, IFIDWrite, IDEX_bubble, IFID_flush};

  hazard_detection_unit #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .RS1_IFID       (RS1_IFID),
    .RS2_IFID       (RS2_IFID),
    .useRS1_ID      (useRS1_ID),
    .useRS2_ID      (useRS2_ID),
    .branch_ID      (branch_ID),
    .branchTaken_ID (branchTaken_ID),
    .mdu_ID         (mdu_ID),
    .RD_IDEX        (RD_IDEX),
    .writeBack_IDEX (writeBack_IDEX),
    .memRead_IDEX   (memRead_IDEX),
    .mdu_IDEX       (mdu_IDEX),
    .RD_EXMEM       (RD_EXMEM),
    .memRead_EXMEM  (memRead_EXMEM),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEX_bubble    (IDEX_bubble),
    .IFID_flush     (IFID_flush),
    .mdu_busy       (mdu_busy),
    .stall_cause    (stall_cause),
    .stall_cycles   (stall_cycles)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RS1_IFID = 5'd0; RS2_IFID = 5'd0; useRS1_ID = 1'b0; useRS2_ID = 1'b0;
    branch_ID = 1'b0; branchTaken_ID = 1'b0; mdu_ID = 1'b0;
    RD_IDEX = 5'd0; writeBack_IDEX = 1'b0; memRead_IDEX = 1'b0; mdu_IDEX = 1'b0;
    RD_EXMEM = 5'd0; memRead_EXMEM = 1'b0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clear_inputs();
    #3;
    // Reset state with all inputs low
    check("rst_ctl",    32'(ctl), 32'(CTL_RUN));
    check("rst_busy",   32'(mdu_busy), 0);
    check("rst_cause",  32'(stall_cause), 0);
    check("rst_cycles", 32'(stall_cycles), 0);

    // Load-use
    do_reset();
    RD_IDEX = 5'd5; memRead_IDEX = 1'b1; writeBack_IDEX = 1'b1;
    RS1_IFID = 5'd5; useRS1_ID = 1'b1;
    #1;
    check("lu_ctl",   32'(ctl), 32'(CTL_STALL));
    check("lu_cause", 32'(stall_cause), 1);
    tick();
    RD_IDEX = 5'd0; memRead_IDEX = 1'b0; writeBack_IDEX = 1'b0;
    #1;
    check("lu_release_ctl", 32'(ctl), 32'(CTL_RUN));
    check("lu_cycles",      32'(stall_cycles), 1);
    RD_IDEX = 5'd0; memRead_IDEX = 1'b1; RS1_IFID = 5'd0;
    #1;
    check("lu_r0_ctl", 32'(ctl), 32'(CTL_RUN));
    RD_IDEX = 5'd5; RS1_IFID = 5'd5; useRS1_ID = 1'b0;
    #1;
    check("lu_nouse_ctl", 32'(ctl), 32'(CTL_RUN));
    RS2_IFID = 5'd5; useRS2_ID = 1'b1;
    #1;
    check("lu_rs2_ctl", 32'(ctl), 32'(CTL_STALL));
    tick();
    clear_inputs();
    #1;
    check("lu_cycles2", 32'(stall_cycles), 2);

    // Branch after load: two stall cycles, then the flush
    do_reset();
    RD_IDEX = 5'd3; memRead_IDEX = 1'b1; writeBack_IDEX = 1'b1;
    RS1_IFID = 5'd3; useRS1_ID = 1'b1; branch_ID = 1'b1; branchTaken_ID = 1'b1;
    #1;
    check("bl_c1_ctl",   32'(ctl), 32'(CTL_STALL));
    check("bl_c1_cause", 32'(stall_cause), 1);
    tick();
    RD_IDEX = 5'd0; memRead_IDEX = 1'b0; writeBack_IDEX = 1'b0;
    RD_EXMEM = 5'd3; memRead_EXMEM = 1'b1;
    #1;
    check("bl_c2_ctl",   32'(ctl), 32'(CTL_STALL));
    check("bl_c2_cause", 32'(stall_cause), 2);
    tick();
    RD_EXMEM = 5'd0; memRead_EXMEM = 1'b0;
    #1;
    check("bl_c3_ctl",    32'(ctl), 32'(CTL_FLUSH));
    check("bl_c3_cause",  32'(stall_cause), 0);
    check("bl_c3_cycles", 32'(stall_cycles), 2);
    // ALU producer in EX for an ID branch, then the same producer for a non-branch
    clear_inputs();
    RD_IDEX = 5'd4; writeBack_IDEX = 1'b1; RS2_IFID = 5'd4; useRS2_ID = 1'b1; branch_ID = 1'b1;
    #1;
    check("ba_ctl",   32'(ctl), 32'(CTL_STALL));
    check("ba_cause", 32'(stall_cause), 2);
    branch_ID = 1'b0;
    #1;
    check("alu_fwd_ctl", 32'(ctl), 32'(CTL_RUN));
    // Non-taken branch with no hazard does not flush
    clear_inputs();
    branch_ID = 1'b1;
    #1;
    check("bnt_ctl", 32'(ctl), 32'(CTL_RUN));

    // MDU dependency
    do_reset();
    mdu_IDEX = 1'b1; RD_IDEX = 5'd7; writeBack_IDEX = 1'b1;
    RS1_IFID = 5'd1; useRS1_ID = 1'b1;
    #1;
    check("mdu_t0_busy", 32'(mdu_busy), 0);
    check("mdu_t0_ctl",  32'(ctl), 32'(CTL_RUN));
    tick();
    clear_inputs();
    RS1_IFID = 5'd2; RS2_IFID = 5'd3; useRS1_ID = 1'b1; useRS2_ID = 1'b1;
    #1;
    check("mdu_t1_busy",  32'(mdu_busy), 1);
    check("mdu_indep",    32'(ctl), 32'(CTL_RUN));
    RS2_IFID = 5'd7;
    #1;
    check("mdu_t1_ctl",   32'(ctl), 32'(CTL_STALL));
    check("mdu_t1_cause", 32'(stall_cause), 3);
    tick();
    check("mdu_t2_ctl", 32'(ctl), 32'(CTL_STALL));
    tick();
    check("mdu_t3_ctl",  32'(ctl), 32'(CTL_STALL));
    check("mdu_t3_busy", 32'(mdu_busy), 1);
    tick();
    check("mdu_t4_ctl",    32'(ctl), 32'(CTL_RUN));
    check("mdu_t4_busy",   32'(mdu_busy), 0);
    check("mdu_t4_cycles", 32'(stall_cycles), 3);

    // Back-to-back MDU ops, then a reload while busy
    do_reset();
    mdu_IDEX = 1'b1; RD_IDEX = 5'd7;
    tick();
    clear_inputs();
    mdu_ID = 1'b1;
    #1;
    check("b2b_t1_ctl",   32'(ctl), 32'(CTL_STALL));
    check("b2b_t1_cause", 32'(stall_cause), 3);
    tick();
    tick();
    check("b2b_t3_ctl", 32'(ctl), 32'(CTL_STALL));
    tick();
    check("b2b_t4_ctl", 32'(ctl), 32'(CTL_RUN));
    tick();
    mdu_ID = 1'b0; mdu_IDEX = 1'b1; RD_IDEX = 5'd9;
    tick();
    clear_inputs();
    RS1_IFID = 5'd9; useRS1_ID = 1'b1;
    #1;
    check("b2b_new_rd", 32'(ctl), 32'(CTL_STALL));
    RS1_IFID = 5'd7;
    #1;
    check("b2b_old_rd", 32'(ctl), 32'(CTL_RUN));
    clear_inputs();
    mdu_IDEX = 1'b1; RD_IDEX = 5'd10;
    tick();
    clear_inputs();
    RS1_IFID = 5'd10; useRS1_ID = 1'b1;
    #1;
    check("reload_rd", 32'(ctl), 32'(CTL_STALL));
    clear_inputs();
    tick();
    tick();
    check("reload_busy_t9",  32'(mdu_busy), 1);
    tick();
    check("reload_busy_t10", 32'(mdu_busy), 0);

    // Reset in the middle of an MDU op
    do_reset();
    mdu_IDEX = 1'b1; RD_IDEX = 5'd7;
    tick();
    clear_inputs();
    RS1_IFID = 5'd7; useRS1_ID = 1'b1;
    tick();
    check("rm_pre_cycles", 32'(stall_cycles), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_busy",   32'(mdu_busy), 0);
    check("rm_cycles", 32'(stall_cycles), 0);
    check("rm_ctl",    32'(ctl), 32'(CTL_RUN));
    tick();
    rst = 1'b1;
    tick();
    check("rm_post_ctl",    32'(ctl), 32'(CTL_RUN));
    check("rm_post_cycles", 32'(stall_cycles), 0);

    // Stall counter saturation
    do_reset();
    RD_IDEX = 5'd6; memRead_IDEX = 1'b1; RS1_IFID = 5'd6; useRS1_ID = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(stall_cycles), 14);
    tick();
    check("sat_15", 32'(stall_cycles), 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_20", 32'(stall_cycles), 15);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
